dec_stage: RTL and testbench

DEC_STAGE -- requirements
Module: dec_stage

---
 rtl/dec_stage.sv | 255 +++++++++++++++++++++++++
 tb/tb_dec_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dec_stage.sv
// dec_stage: single-entry registered RISC-V decode stage.
// Decodes in_ir combinationally and captures the control bundle on accept.
// Holds back for one cycle when the incoming instruction reads the
// destination of a load that was accepted on the previous cycle.
module dec_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int EN_M  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            MA,
    output logic            MB,
    output logic            MD,
    output logic            RW,
    output logic            MW,
    output logic            MR,
    output logic            PL,
    output logic            JL,
    output logic            JLR,
    output logic            BR,
    output logic [4:0]      FS,
    output logic [2:0]      BMC,
    output logic [4:0]      AA,
    output logic [4:0]      BA,
    output logic [4:0]      DA,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);

    typedef enum logic [4:0] {
        OPC_LOAD   = 5'b00000,
        OPC_OPIMM  = 5'b00100,
        OPC_AUIPC  = 5'b00101,
        OPC_STORE  = 5'b01000,
        OPC_OP     = 5'b01100,
        OPC_LUI    = 5'b01101,
        OPC_BRANCH = 5'b11000,
        OPC_JALR   = 5'b11001,
        OPC_JAL    = 5'b11011
    } opcode_e;

    typedef struct packed {
        logic            ma;
        logic            mb;
        logic            md;
        logic            rw;
        logic            mw;
        logic            mr;
        logic            pl;
        logic            jl;
        logic            jlr;
        logic            br;
        logic [4:0]      fs;
        logic [2:0]      bmc;
        logic [4:0]      aa;
        logic [4:0]      ba;
        logic [4:0]      da;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    opcode_e     opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;

    assign opc = opcode_e'(in_ir[6:2]);
    assign rd  = in_ir[11:7];
    assign f3  = in_ir[14:12];
    assign rs1 = in_ir[19:15];
    assign rs2 = in_ir[24:20];
    assign f7  = in_ir[31:25];

    bundle_t     dec;
    logic [31:0] imm32;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;
    logic        op_ok;
    logic        reg_bad;

    bundle_t     bundle_d,    bundle_q;
    logic        out_valid_d, out_valid_q;
    logic        ld_pend_d,   ld_pend_q;
    logic [4:0]  ld_rd_d,     ld_rd_q;
    logic        stall;
    logic        accept;

    // Combinational decode of in_ir into a control bundle
    always_comb begin
        dec     = '0;
        imm32   = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        op_ok   = 1'b1;
        dec.bmc = f3;
        dec.aa  = rs1;
        dec.ba  = rs2;
        dec.da  = rd;
        dec.pc  = in_pc;
        case (opc)
            OPC_OP: begin
                dec.rw = 1'b1; dec.pl = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                if (f7 == 7'b0000000)
                    dec.fs = {1'b0, in_ir[30], f3};
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    dec.fs = {1'b0, in_ir[30], f3};
                else if (f7 == 7'b0000001 && EN_M != 0)
                    dec.fs = {2'b10, f3};
                else
                    op_ok = 1'b0;
            end
            OPC_OPIMM: begin
                dec.mb = 1'b1; dec.rw = 1'b1; dec.pl = 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1;
                dec.fs = (f3 == 3'b101) ? {1'b0, in_ir[30], f3} : {2'b00, f3};
                imm32  = {{20{in_ir[31]}}, in_ir[31:20]};
            end
            OPC_LOAD: begin
                dec.mb = 1'b1; dec.md = 1'b1; dec.rw = 1'b1; dec.mr = 1'b1; dec.pl = 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm32 = {{20{in_ir[31]}}, in_ir[31:20]};
                op_ok = !(f3 == 3'b011 || f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec.mb = 1'b1; dec.mw = 1'b1; dec.pl = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm32 = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
                op_ok = (f3 <= 3'b010);
            end
            OPC_BRANCH: begin
                dec.br = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm32 = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
                case (f3[2:1])
                    2'b00:   dec.fs = 5'b01000;
                    2'b10:   dec.fs = 5'b00010;
                    2'b11:   dec.fs = 5'b00011;
                    default: op_ok  = 1'b0;
                endcase
            end
            OPC_JALR: begin
                dec.mb = 1'b1; dec.rw = 1'b1; dec.jlr = 1'b1;
                use_rs1 = 1'b1; use_rd = 1'b1;
                imm32 = {{20{in_ir[31]}}, in_ir[31:20]};
                op_ok = (f3 == 3'b000);
            end
            OPC_JAL: begin
                dec.rw = 1'b1; dec.jl = 1'b1;
                use_rd = 1'b1;
                imm32 = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
            end
            OPC_AUIPC: begin
                dec.ma = 1'b1; dec.mb = 1'b1; dec.rw = 1'b1; dec.pl = 1'b1;
                use_rd = 1'b1;
                imm32 = {in_ir[31:12], 12'h000};
            end
            OPC_LUI: begin
                dec.mb = 1'b1; dec.rw = 1'b1; dec.pl = 1'b1;
                use_rd = 1'b1;
                dec.aa = '0;
                imm32  = {in_ir[31:12], 12'h000};
            end
            default: op_ok = 1'b0;
        endcase
        dec.imm = XLEN'($signed(imm32));
        reg_bad = (NREGS == 16) &&
                  ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]));
        if (in_ir[1:0] != 2'b11 || !op_ok || reg_bad) begin
            dec.illegal = 1'b1;
            dec.pl  = 1'b1;
            dec.rw  = 1'b0;
            dec.mw  = 1'b0;
            dec.mr  = 1'b0;
            dec.br  = 1'b0;
            dec.jl  = 1'b0;
            dec.jlr = 1'b0;
        end
    end

    assign stall    = ld_pend_q && in_valid &&
                      ((use_rs1 && rs1 == ld_rd_q) || (use_rs2 && rs2 == ld_rd_q));
    assign in_ready = (!out_valid_q || out_ready) && !stall && !flush;
    assign accept   = in_valid && in_ready;

    // Next-state: entry capture/drain and the one-cycle load-use marker
    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        ld_pend_d   = 1'b0;
        ld_rd_d     = ld_rd_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            bundle_d    = dec;
            if (opc == OPC_LOAD && !dec.illegal && rd != 5'd0) begin
                ld_pend_d = 1'b1;
                ld_rd_d   = rd;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
            ld_pend_q   <= 1'b0;
            ld_rd_q     <= '0;
        end else begin
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
            ld_pend_q   <= ld_pend_d;
            ld_rd_q     <= ld_rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign MA      = bundle_q.ma;
    assign MB      = bundle_q.mb;
    assign MD      = bundle_q.md;
    assign RW      = bundle_q.rw;
    assign MW      = bundle_q.mw;
    assign MR      = bundle_q.mr;
    assign PL      = bundle_q.pl;
    assign JL      = bundle_q.jl;
    assign JLR     = bundle_q.jlr;
    assign BR      = bundle_q.br;
    assign FS      = bundle_q.fs;
    assign BMC     = bundle_q.bmc;
    assign AA      = bundle_q.aa;
    assign BA      = bundle_q.ba;
    assign DA      = bundle_q.da;
    assign imm     = bundle_q.imm;
    assign pc_out  = bundle_q.pc;
    assign illegal = bundle_q.illegal;

endmodule

// File: tb/tb_dec_stage.sv
// tb_dec_stage: directed checks of dec_stage using two instances,
// u_a (XLEN=64, NREGS=32, EN_M=0) and u_b (XLEN=32, NREGS=16, EN_M=1),
// both driven by the same stimulus.
module tb_dec_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_ir;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_ma, a_mb, a_md, a_rw, a_mw, a_mr, a_pl, a_jl, a_jlr, a_br, a_illegal;
    logic [4:0]  a_fs, a_aa, a_ba, a_da;
    logic [2:0]  a_bmc;
    logic [63:0] a_imm, a_pc_out;

    logic        b_in_ready, b_out_valid, b_ma, b_mb, b_md, b_rw, b_mw, b_mr, b_pl, b_jl, b_jlr, b_br, b_illegal;
    logic [4:0]  b_fs, b_aa, b_ba, b_da;
    logic [2:0]  b_bmc;
    logic [31:0] b_imm, b_pc_out;

    // Control vector order: MA MB MD RW MW MR PL JL JLR BR
    logic [9:0]  a_ctl;
    assign a_ctl = {a_ma, a_mb, a_md, a_rw, a_mw, a_mr, a_pl, a_jl, a_jlr, a_br};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dec_stage #(.XLEN(64), .NREGS(32), .EN_M(0)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ir(in_ir), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .MA(a_ma), .MB(a_mb), .MD(a_md), .RW(a_rw), .MW(a_mw), .MR(a_mr), .PL(a_pl),
        .JL(a_jl), .JLR(a_jlr), .BR(a_br), .FS(a_fs), .BMC(a_bmc), .AA(a_aa), .BA(a_ba),
        .DA(a_da), .imm(a_imm), .pc_out(a_pc_out), .illegal(a_illegal)
    );

    dec_stage #(.XLEN(32), .NREGS(16), .EN_M(1)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ir(in_ir), .in_pc(in_pc[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
        .MA(b_ma), .MB(b_mb), .MD(b_md), .RW(b_rw), .MW(b_mw), .MR(b_mr), .PL(b_pl),
        .JL(b_jl), .JLR(b_jlr), .BR(b_br), .FS(b_fs), .BMC(b_bmc), .AA(b_aa), .BA(b_ba),
        .DA(b_da), .imm(b_imm), .pc_out(b_pc_out), .illegal(b_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [63:0] pc);
        in_valid = v;
        in_ir    = ir;
        in_pc    = pc;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 32'h002081B3, 64'h40);
        tick(); tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_out_valid); end
        checks++; if (a_ctl !== 10'b0) begin errors++; $display("FAIL reset_ctl: got %b want 0", a_ctl); end
        checks++; if ({a_fs, a_bmc, a_aa, a_ba, a_da, a_illegal} !== 24'h0) begin errors++; $display("FAIL reset_fields: got %h want 0", {a_fs, a_bmc, a_aa, a_ba, a_da, a_illegal}); end
        checks++; if ({a_imm, a_pc_out} !== 128'h0) begin errors++; $display("FAIL reset_imm_pc: got %h want 0", {a_imm, a_pc_out}); end
        rst = 1'b0;
        drive(1'b0, 32'h0, 64'h0);
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    endtask

    task automatic test_add();
        drive(1'b1, 32'h002081B3, 64'h100);
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b want 1", a_in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", a_out_valid); end
        checks++; if (a_ctl !== 10'b0001001000) begin errors++; $display("FAIL add_ctl: got %b want 0001001000", a_ctl); end
        checks++; if ({a_fs, a_aa, a_ba, a_da, a_illegal} !== {5'd0, 5'd1, 5'd2, 5'd3, 1'b0}) begin errors++; $display("FAIL add_fields: got fs=%b aa=%0d ba=%0d da=%0d ill=%b", a_fs, a_aa, a_ba, a_da, a_illegal); end
        checks++; if ({a_imm, a_pc_out} !== {64'h0, 64'h100}) begin errors++; $display("FAIL add_imm_pc: got imm=%h pc=%h want 0/100", a_imm, a_pc_out); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", a_out_valid); end
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h0000A283, 64'h200);               // lw x5,0(x1)
        tick();
        checks++; if (a_ctl !== 10'b0111011000 || a_da !== 5'd5) begin errors++; $display("FAIL lw_ctl: got ctl=%b da=%0d want 0111011000/5", a_ctl, a_da); end
        drive(1'b1, 32'h00028333, 64'h204);               // add x6,x5,x0
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: got in_ready=%b want 0", a_in_ready); end
        tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got out_valid=%b want 0", a_out_valid); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL lu_release: got in_ready=%b want 1", a_in_ready); end
        tick();
        checks++; if ({a_out_valid, a_aa, a_da, a_pc_out[15:0]} !== {1'b1, 5'd5, 5'd6, 16'h204}) begin errors++; $display("FAIL lu_add: got v=%b aa=%0d da=%0d pc=%h", a_out_valid, a_aa, a_da, a_pc_out); end
        // load followed by an independent op, then a reader: no bubble anywhere
        drive(1'b1, 32'h0000A283, 64'h300);
        tick();
        drive(1'b1, 32'h00100393, 64'h304);               // addi x7,x0,1
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL lu_indep: got in_ready=%b want 1", a_in_ready); end
        tick();
        drive(1'b1, 32'h00028333, 64'h308);
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL lu_late_reader: got in_ready=%b want 1", a_in_ready); end
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_m_ext();
        drive(1'b1, 32'h022081B3, 64'h400);               // mul x3,x1,x2
        tick();
        in_valid = 1'b0;
        checks++; if ({a_illegal, a_rw, a_pl} !== 3'b101) begin errors++; $display("FAIL mul_noM: got ill/rw/pl=%b want 101", {a_illegal, a_rw, a_pl}); end
        checks++; if ({b_illegal, b_rw, b_fs} !== {2'b01, 5'b10000}) begin errors++; $display("FAIL mul_M: got ill=%b rw=%b fs=%b want 0/1/10000", b_illegal, b_rw, b_fs); end
    endtask

    task automatic test_branch();
        drive(1'b1, 32'hFE208EE3, 64'h500);               // beq x1,x2,-4
        tick();
        checks++; if (a_ctl !== 10'b0000000001 || a_fs !== 5'b01000 || a_bmc !== 3'b000) begin errors++; $display("FAIL beq_ctl: got ctl=%b fs=%b bmc=%b", a_ctl, a_fs, a_bmc); end
        checks++; if (a_imm !== 64'hFFFFFFFFFFFFFFFC) begin errors++; $display("FAIL beq_imm: got %h want FFFFFFFFFFFFFFFC", a_imm); end
        drive(1'b1, 32'hFE20DEE3, 64'h504);               // bge x1,x2,-4
        tick();
        checks++; if (a_fs !== 5'b00010 || a_bmc !== 3'b101 || a_br !== 1'b1) begin errors++; $display("FAIL bge: got fs=%b bmc=%b br=%b", a_fs, a_bmc, a_br); end
        drive(1'b1, 32'hFE20AEE3, 64'h508);               // branch funct3=010
        tick();
        in_valid = 1'b0;
        checks++; if ({a_illegal, a_br, a_pl} !== 3'b101) begin errors++; $display("FAIL br_f3_010: got ill/br/pl=%b want 101", {a_illegal, a_br, a_pl}); end
    endtask

    task automatic test_imm_formats();
        drive(1'b1, 32'h0020A423, 64'h600);               // sw x2,8(x1)
        tick();
        checks++; if (a_ctl !== 10'b0100101000 || a_imm !== 64'd8 || a_fs !== 5'd0) begin errors++; $display("FAIL sw: got ctl=%b imm=%h fs=%b", a_ctl, a_imm, a_fs); end
        drive(1'b1, 32'h123450B7, 64'h604);               // lui x1,0x12345
        tick();
        checks++; if (a_ctl !== 10'b0101001000 || a_imm !== 64'h12345000 || a_aa !== 5'd0) begin errors++; $display("FAIL lui: got ctl=%b imm=%h aa=%0d", a_ctl, a_imm, a_aa); end
        drive(1'b1, 32'h800000B7, 64'h608);               // lui x1,0x80000
        tick();
        checks++; if (a_imm !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL lui_sext: got %h want FFFFFFFF80000000", a_imm); end
        drive(1'b1, 32'h008000EF, 64'h60C);               // jal x1,8
        tick();
        in_valid = 1'b0;
        checks++; if (a_ctl !== 10'b0001000100 || a_imm !== 64'd8 || a_da !== 5'd1) begin errors++; $display("FAIL jal: got ctl=%b imm=%h da=%0d", a_ctl, a_imm, a_da); end
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'h00000000, 64'h700);               // low bits 00
        tick();
        checks++; if ({a_illegal, a_pl, a_rw, a_mr} !== 4'b1100) begin errors++; $display("FAIL ill_lowbits: got ill/pl/rw/mr=%b want 1100", {a_illegal, a_pl, a_rw, a_mr}); end
        drive(1'b1, 32'h0000107F, 64'h704);               // opcode 11111
        tick();
        checks++; if ({a_illegal, a_pl} !== 2'b11) begin errors++; $display("FAIL ill_opcode: got ill/pl=%b want 11", {a_illegal, a_pl}); end
        drive(1'b1, 32'h000090E7, 64'h708);               // jalr funct3=001
        tick();
        in_valid = 1'b0;
        checks++; if ({a_illegal, a_jlr, a_rw} !== 3'b100) begin errors++; $display("FAIL ill_jalr: got ill/jlr/rw=%b want 100", {a_illegal, a_jlr, a_rw}); end
    endtask

    task automatic test_backpressure_flush();
        tick();
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 64'h800);
        tick();
        drive(1'b1, 32'h00100393, 64'h804);
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", a_in_ready); end
        tick();
        checks++; if ({a_out_valid, a_da, a_pc_out[15:0]} !== {1'b1, 5'd3, 16'h800}) begin errors++; $display("FAIL bp_hold: got v=%b da=%0d pc=%h", a_out_valid, a_da, a_pc_out); end
        flush = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", a_in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", a_out_valid); end
        out_ready = 1'b1;
        // flush with an empty stage and a valid input must not capture it
        flush = 1'b1;
        drive(1'b1, 32'h002081B3, 64'h900);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_prio: got %b want 0", a_out_valid); end
    endtask

    task automatic test_rst_mid_stall();
        drive(1'b1, 32'h0000A283, 64'hA00);
        tick();
        drive(1'b1, 32'h00028333, 64'hA04);
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rs_stall: got in_ready=%b want 0", a_in_ready); end
        rst = 1'b1;
        tick();
        checks++; if ({a_out_valid, a_ctl, a_fs, a_bmc, a_aa, a_ba, a_da, a_illegal} !== 35'h0) begin errors++; $display("FAIL rs_outputs: got v=%b ctl=%b fs=%b da=%0d", a_out_valid, a_ctl, a_fs, a_da); end
        checks++; if ({a_imm, a_pc_out} !== 128'h0) begin errors++; $display("FAIL rs_imm_pc: got %h want 0", {a_imm, a_pc_out}); end
        rst = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rs_ld_pend: got in_ready=%b want 1", a_in_ready); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_nregs16();
        drive(1'b1, 32'h00100893, 64'hB00);               // addi x17,x0,1
        tick();
        in_valid = 1'b0;
        checks++; if ({b_illegal, b_rw} !== 2'b10) begin errors++; $display("FAIL rv32e_x17: got ill/rw=%b want 10", {b_illegal, b_rw}); end
        checks++; if ({a_illegal, a_rw, a_da} !== {2'b01, 5'd17}) begin errors++; $display("FAIL rv32i_x17: got ill=%b rw=%b da=%0d", a_illegal, a_rw, a_da); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ir = '0; in_pc = '0;
        test_reset();
        test_add();
        test_load_use();
        test_m_ext();
        test_branch();
        test_imm_formats();
        test_illegal();
        test_backpressure_flush();
        test_rst_mid_stall();
        test_nregs16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
